// File: rtl/led_blink_sched.sv
// Round-robin shared blink scheduler: grants one requester at a time and plays N ON/OFF blinks then a GAP.
// Optional LED_BLINK_SCHED_ABORT_EN adds an abort input that ends a running burst early.
module led_blink_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ON_CYCLES  = 12500000,
    parameter int unsigned OFF_CYCLES = 12500000,
    parameter int unsigned GAP_CYCLES = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] count,
`ifdef LED_BLINK_SCHED_ABORT_EN
    input  logic                 abort,
`endif
    output logic [NUM_REQ-1:0]   ack,
    output logic [2:0]           owner,
    output logic                 busy,
    output logic                 done,
    output logic                 led
);

    localparam int unsigned MAX_ONOFF  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned MAX_PERIOD = (MAX_ONOFF > GAP_CYCLES) ? MAX_ONOFF : GAP_CYCLES;
    localparam int unsigned TW         = $clog2(MAX_PERIOD + 1);

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

    state_t              state, state_next;
    logic [TW-1:0]       timer, timer_next;
    logic [4:0]          remaining, remaining_next;
    logic [2:0]          rr_ptr, rr_ptr_next;
    logic                grant_valid;
    logic [2:0]          grant_idx;
    logic [3:0]          grant_cnt;
    logic                abort_now;
    logic [NUM_REQ-1:0]  ack_next;
    logic [2:0]          owner_next;
    logic                busy_next, done_next, led_next;

`ifdef LED_BLINK_SCHED_ABORT_EN
    assign abort_now = abort && (state != S_IDLE);
`else
    assign abort_now = 1'b0;
`endif

    // Search priority order rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; first pending wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_cnt   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!grant_valid && req[j] &&
                    ((j == 32'(rr_ptr) + i) || (j + NUM_REQ == 32'(rr_ptr) + i))) begin
                    grant_valid = 1'b1;
                    grant_idx   = 3'(j);
                    grant_cnt   = count[4*j +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            timer     <= '0;
            remaining <= '0;
            rr_ptr    <= '0;
            ack       <= '0;
            owner     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            led       <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            remaining <= remaining_next;
            rr_ptr    <= rr_ptr_next;
            ack       <= ack_next;
            owner     <= owner_next;
            busy      <= busy_next;
            done      <= done_next;
            led       <= led_next;
        end
    end

    always_comb begin
        state_next     = state;
        timer_next     = timer;
        remaining_next = remaining;
        case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    state_next     = S_ON;
                    timer_next     = '0;
                    remaining_next = (grant_cnt == 4'd0) ? 5'd16 : {1'b0, grant_cnt};
                end
            end
            S_ON: begin
                if (timer == ON_LAST) begin
                    state_next = S_OFF;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            S_OFF: begin
                if (timer == OFF_LAST) begin
                    timer_next = '0;
                    if (remaining > 5'd1) begin
                        remaining_next = remaining - 5'd1;
                        state_next     = S_ON;
                    end else begin
                        state_next = S_GAP;
                    end
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            S_GAP: begin
                if (timer == GAP_LAST) begin
                    state_next = S_IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (abort_now) begin
            state_next     = S_IDLE;
            timer_next     = '0;
            remaining_next = '0;
        end
    end

    // Registered outputs are driven from next-state so led/ack rise on the grant edge itself.
    always_comb begin
        ack_next    = '0;
        owner_next  = owner;
        rr_ptr_next = rr_ptr;
        if (state == S_IDLE && grant_valid) begin
            ack_next    = NUM_REQ'(1) << grant_idx;
            owner_next  = grant_idx;
            rr_ptr_next = (32'(grant_idx) == NUM_REQ - 1) ? 3'd0 : grant_idx + 3'd1;
        end
        led_next  = (state_next == S_ON);
        busy_next = (state_next != S_IDLE);
        done_next = (state != S_IDLE) && (state_next == S_IDLE);
    end

endmodule

// File: tb/tb_led_blink_sched.sv
// Directed bench for led_blink_sched with ON=3, OFF=2, GAP=4, NUM_REQ=4.
// Abort scenario is compiled in when LED_BLINK_SCHED_ABORT_EN is defined.
module tb_led_blink_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] count;
`ifdef LED_BLINK_SCHED_ABORT_EN
    logic        abort;
`endif
    logic [3:0]  ack;
    logic [2:0]  owner;
    logic        busy, done, led;

    int   vectors     = 0;
    int   miscompares = 0;
    int   c, pulses, run;
    logic prev_led, done_seen;
    logic [3:0] exp_ack [0:4];

    led_blink_sched #(
        .NUM_REQ    (4),
        .ON_CYCLES  (3),
        .OFF_CYCLES (2),
        .GAP_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .count (count),
`ifdef LED_BLINK_SCHED_ABORT_EN
        .abort (abort),
`endif
        .ack   (ack),
        .owner (owner),
        .busy  (busy),
        .done  (done),
        .led   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed no finish, required finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // reset held with all requests pending
        rst   = 1'b1;
        req   = 4'b1111;
        count = 16'h0000;
`ifdef LED_BLINK_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_led",   32'(led),   32'd0);
            check("rst_ack",   32'(ack),   32'd0);
            check("rst_busy",  32'(busy),  32'd0);
            check("rst_done",  32'(done),  32'd0);
            check("rst_owner", 32'(owner), 32'd0);
        end

        // single requester 2, two blinks
        rst   = 1'b0;
        req   = 4'b0100;
        count = 16'h0200;
        tick();
        check("t2_ack0",   32'(ack),   32'h4);
        check("t2_led0",   32'(led),   32'd1);
        check("t2_owner",  32'(owner), 32'd2);
        check("t2_busy0",  32'(busy),  32'd1);
        check("t2_done0",  32'(done),  32'd0);
        req   = 4'b0000;
        count = 16'h0700;
        for (int cy = 1; cy <= 14; cy++) begin
            tick();
            check("t2_led",  32'(led),  32'((cy <= 2) || (cy >= 5 && cy <= 7)));
            check("t2_done", 32'(done), 32'(cy == 14));
            check("t2_busy", 32'(busy), 32'(cy != 14));
            check("t2_ack",  32'(ack),  32'd0);
        end

        // round robin over all four, count=1 each
        rst = 1'b1;
        tick();
        check("t3_rst_owner", 32'(owner), 32'd0);
        rst   = 1'b0;
        req   = 4'b1111;
        count = 16'h1111;
        exp_ack[0] = 4'b0001;
        exp_ack[1] = 4'b0010;
        exp_ack[2] = 4'b0100;
        exp_ack[3] = 4'b1000;
        exp_ack[4] = 4'b0001;
        tick();
        check("t3_ack_first", 32'(ack), 32'(exp_ack[0]));
        req = req & ~exp_ack[0];
        for (int k = 1; k < 5; k++) begin
            if (k == 4) req = 4'b0001;
            repeat (9) tick();
            check("t3_done", 32'(done), 32'd1);
            check("t3_busy", 32'(busy), 32'd0);
            check("t3_gap_ack", 32'(ack), 32'd0);
            tick();
            check("t3_ack", 32'(ack), 32'(exp_ack[k]));
            req = req & ~exp_ack[k];
        end
        repeat (9) tick();
        check("t3_tail_done", 32'(done), 32'd1);

        // count=0 means 16 blinks
        req   = 4'b0010;
        count = 16'h0000;
        tick();
        check("t4_ack",  32'(ack), 32'h2);
        check("t4_led0", 32'(led), 32'd1);
        req       = 4'b0000;
        pulses    = 1;
        run       = 1;
        prev_led  = 1'b1;
        done_seen = 1'b0;
        c         = 0;
        while (!done_seen && c < 200) begin
            tick();
            c++;
            if (led) begin
                if (!prev_led) begin
                    pulses++;
                    run = 0;
                end
                run++;
            end else if (prev_led) begin
                check("t4_high_len", 32'(run), 32'd3);
            end
            prev_led = led;
            if (done) done_seen = 1'b1;
        end
        check("t4_pulses",     32'(pulses),    32'd16);
        check("t4_done_cycle", 32'(c),         32'd84);
        check("t4_done_seen",  32'(done_seen), 32'd1);

        // reset in 2nd ON period; held req[3] is granted first afterwards
        req   = 4'b0001;
        count = 16'h1003;
        tick();
        check("t5_ack0", 32'(ack), 32'h1);
        req = 4'b1000;
        repeat (6) tick();
        check("t5_led_on2",      32'(led), 32'd1);
        check("t5_pending_ack",  32'(ack), 32'd0);
        rst = 1'b1;
        tick();
        check("t5_rst_led",   32'(led),   32'd0);
        check("t5_rst_busy",  32'(busy),  32'd0);
        check("t5_rst_done",  32'(done),  32'd0);
        check("t5_rst_owner", 32'(owner), 32'd0);
        rst = 1'b0;
        tick();
        check("t5_no_done", 32'(done),  32'd0);
        check("t5_ack3",    32'(ack),   32'h8);
        check("t5_owner3",  32'(owner), 32'd3);
        check("t5_led",     32'(led),   32'd1);
        req = 4'b0000;
        repeat (9) tick();
        check("t5_done", 32'(done), 32'd1);

`ifdef LED_BLINK_SCHED_ABORT_EN
        // abort in cycle 4 of a count=5 burst, req[1] pending
        req   = 4'b0011;
        count = 16'h0015;
        tick();
        check("t6_ack0", 32'(ack), 32'h1);
        req = 4'b0010;
        repeat (4) tick();
        check("t6_led4",  32'(led),  32'd0);
        check("t6_busy4", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        check("t6_led5",  32'(led),  32'd0);
        check("t6_done5", 32'(done), 32'd1);
        check("t6_busy5", 32'(busy), 32'd0);
        check("t6_ack5",  32'(ack),  32'd0);
        tick();
        check("t6_ack6",   32'(ack),   32'h2);
        check("t6_owner6", 32'(owner), 32'd1);
        check("t6_led6",   32'(led),   32'd1);
        abort = 1'b0;
        req   = 4'b0000;
        repeat (9) tick();
        check("t6_done", 32'(done), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
